varredura_servo: RTL and testbench

//   Upstream stage of circuito_pwm: drives its 3-bit largura input to sweep the servo 0..7..0 (ping-pong).
//   At each position it waits a settling time, then requests one sonar measurement and waits for its completion.

---
 rtl/varredura_servo_pkg.sv | 42 ++++
 rtl/varredura_servo_contador_timer.sv | 23 ++
 rtl/varredura_servo.sv | 103 ++++++++++
 tb/tb_varredura_servo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/varredura_servo_pkg.sv
// Shared types for the servo sweep controller: state codes, end position and
// the ping-pong position step used when the sweep advances.
package varredura_servo_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    ACOMODA = 3'd1,
    PEDE    = 3'd2,
    ESPERA  = 3'd3,
    AVANCA  = 3'd4
  } estado_t;

  localparam logic [2:0] POS_MAX = 3'd7;

  typedef struct packed {
    logic       direcao;
    logic [2:0] largura;
  } posicao_t;

  // Endpoints reverse in place so each end is measured once per pass.
  function automatic posicao_t proxima_posicao(input posicao_t atual);
    posicao_t prox;
    prox = atual;
    if (!atual.direcao) begin
      if (atual.largura < POS_MAX) begin
        prox.largura = atual.largura + 3'd1;
      end else begin
        prox.direcao = 1'b1;
        prox.largura = POS_MAX - 3'd1;
      end
    end else begin
      if (atual.largura > 3'd0) begin
        prox.largura = atual.largura - 3'd1;
      end else begin
        prox.direcao = 1'b0;
        prox.largura = 3'd1;
      end
    end
    return prox;
  endfunction

endpackage

// File: rtl/varredura_servo_contador_timer.sv
// 32-bit cycle counter with synchronous clear and enable; fim flags the last
// cycle of a window of limite cycles.
module contador_timer (
  input  logic        clock,
  input  logic        limpa,
  input  logic        conta,
  input  logic [31:0] limite,
  output logic        fim
);

  logic [31:0] contagem;

  always_ff @(posedge clock) begin
    if (limpa) begin
      contagem <= 32'd0;
    end else if (conta) begin
      contagem <= contagem + 32'd1;
    end
  end

  assign fim = (contagem == limite - 32'd1);

endmodule

// File: rtl/varredura_servo.sv
// Servo sweep controller: steps largura 0..7..0, settles, requests one sonar
// measurement per position and advances on completion or timeout.
module varredura_servo
  import varredura_servo_pkg::*;
#(
  parameter int unsigned T_ACOMODA = 25_000_000,
  parameter int unsigned T_LIMITE  = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       medida_pronta,
  output logic [2:0] largura,
  output logic       pede_medida,
  output logic       direcao,
  output logic       timeout,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  // Handshake: pede_medida is a one-cycle request while in PEDE; the sonar
  // answers with a one-cycle medida_pronta, which only counts in ESPERA.

  estado_t estado, prox_estado;

  logic [31:0] limite;
  logic        fim, limpa, conta;

  posicao_t pos_atual, pos_prox;
  logic     timeout_prox, pede_prox, ocupado_prox;

  // One shared timer; the window length follows the state that is counting.
  assign limite = (estado == ESPERA) ? 32'(T_LIMITE) : 32'(T_ACOMODA);
  assign conta  = (estado == ACOMODA) || (estado == ESPERA);
  assign limpa  = reset || (prox_estado != estado);

  contador_timer u_timer (
    .clock  (clock),
    .limpa  (limpa),
    .conta  (conta),
    .limite (limite),
    .fim    (fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    if (estado != OCIOSO && parar) begin
      prox_estado = OCIOSO;
    end else begin
      case (estado)
        OCIOSO:  if (iniciar) prox_estado = ACOMODA;
        ACOMODA: if (fim) prox_estado = PEDE;
        PEDE:    prox_estado = ESPERA;
        ESPERA:  if (medida_pronta || fim) prox_estado = AVANCA;
        AVANCA:  prox_estado = ACOMODA;
        default: prox_estado = OCIOSO;
      endcase
    end
  end

  assign pos_atual = {direcao, largura};

  // Outputs are computed from the next state so they can be registered and
  // still line up with the state they belong to.
  always_comb begin
    pos_prox     = pos_atual;
    timeout_prox = 1'b0;
    if (estado == ESPERA && prox_estado == AVANCA) begin
      pos_prox     = proxima_posicao(pos_atual);
      timeout_prox = !medida_pronta;
    end
    pede_prox    = (prox_estado == PEDE);
    ocupado_prox = (prox_estado != OCIOSO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      largura     <= 3'd0;
      direcao     <= 1'b0;
      pede_medida <= 1'b0;
      timeout     <= 1'b0;
      ocupado     <= 1'b0;
    end else begin
      largura     <= pos_prox.largura;
      direcao     <= pos_prox.direcao;
      pede_medida <= pede_prox;
      timeout     <= timeout_prox;
      ocupado     <= ocupado_prox;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_varredura_servo.sv
// Directed bench for varredura_servo with short settle/timeout windows
// (T_ACOMODA=4, T_LIMITE=10).
module tb_varredura_servo;

  logic       clock = 1'b0;
  logic       reset, iniciar, parar, medida_pronta;
  logic [2:0] largura, db_estado;
  logic       pede_medida, direcao, timeout, ocupado;

  int n_checks = 0;
  int n_fail   = 0;

  // Measured positions and direction at each request of the first pass.
  int exp_pos[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int exp_dir[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

  localparam logic [2:0] S_OCIOSO  = 3'd0;
  localparam logic [2:0] S_ACOMODA = 3'd1;
  localparam logic [2:0] S_ESPERA  = 3'd3;
  localparam logic [2:0] S_AVANCA  = 3'd4;

  varredura_servo #(
    .T_ACOMODA (4),
    .T_LIMITE  (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .parar         (parar),
    .medida_pronta (medida_pronta),
    .largura       (largura),
    .pede_medida   (pede_medida),
    .direcao       (direcao),
    .timeout       (timeout),
    .ocupado       (ocupado),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pede(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      iniciar = 1'b0;
      n++;
    end while (!pede_medida && n < 40);
    check({tag, "_pede"}, 32'(pede_medida), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
  endtask

  task automatic wait_timeout(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout && n < 40);
    check({tag, "_to"}, 32'(timeout), 32'd1);
    check({tag, "_to_lat"}, 32'(n), 32'(exp_n));
  endtask

  // Called in the PEDE cycle; answers three cycles later, lands in AVANCA.
  task automatic medir(input string tag, input int next_pos, input int next_dir);
    tick();
    check({tag, "_pulse1"}, 32'(pede_medida), 32'd0);
    tick();
    tick();
    medida_pronta = 1'b1;
    tick();
    medida_pronta = 1'b0;
    check({tag, "_avanca"}, 32'(db_estado), 32'(S_AVANCA));
    check({tag, "_larg"}, 32'(largura), 32'(next_pos));
    check({tag, "_dir"}, 32'(direcao), 32'(next_dir));
    check({tag, "_noto"}, 32'(timeout), 32'd0);
  endtask

  task automatic measure(input string tag, input int pos, input int dir,
                         input int next_pos, input int next_dir);
    wait_pede(tag, 5);
    check({tag, "_at_larg"}, 32'(largura), 32'(pos));
    check({tag, "_at_dir"}, 32'(direcao), 32'(dir));
    medir(tag, next_pos, next_dir);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    parar = 1'b0;
    medida_pronta = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_estado", 32'(db_estado), 32'(S_OCIOSO));
    check("rst_larg", 32'(largura), 32'd0);
    check("rst_dir", 32'(direcao), 32'd0);
    check("rst_ocup", 32'(ocupado), 32'd0);
    check("rst_pede", 32'(pede_medida), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);

    // Full pass 0..7..0 then 1, answering each request after three cycles.
    iniciar = 1'b1;
    for (int i = 0; i < 15; i++) begin
      measure($sformatf("sweep%0d", i), exp_pos[i], exp_dir[i], exp_pos[i+1], exp_dir[i+1]);
    end
    check("sweep_ocup", 32'(ocupado), 32'd1);

    // No answer: timeout ends ESPERA, then the next request 16 cycles on.
    wait_pede("to1", 5);
    check("to1_at_larg", 32'(largura), 32'd1);
    wait_timeout("to1", 11);
    check("to1_larg", 32'(largura), 32'd2);
    check("to1_dir", 32'(direcao), 32'd0);
    tick();
    check("to1_pulse1", 32'(timeout), 32'd0);
    wait_pede("to1_next", 4);
    check("to1_next_larg", 32'(largura), 32'd2);

    // Answer arrives on the very cycle the timer expires.
    for (int i = 0; i < 10; i++) tick();
    check("edge_espera", 32'(db_estado), 32'(S_ESPERA));
    medida_pronta = 1'b1;
    tick();
    medida_pronta = 1'b0;
    check("edge_avanca", 32'(db_estado), 32'(S_AVANCA));
    check("edge_noto", 32'(timeout), 32'd0);
    check("edge_larg", 32'(largura), 32'd3);

    // Stray answer while settling is ignored.
    tick();
    check("stray_acomoda", 32'(db_estado), 32'(S_ACOMODA));
    medida_pronta = 1'b1;
    tick();
    medida_pronta = 1'b0;
    wait_pede("stray", 3);
    check("stray_larg", 32'(largura), 32'd3);
    wait_timeout("stray", 11);
    check("stray_to_larg", 32'(largura), 32'd4);

    // Walk to position 5 descending, then stop while waiting.
    measure("walk4", 4, 0, 5, 0);
    measure("walk5", 5, 0, 6, 0);
    measure("walk6", 6, 0, 7, 0);
    measure("walk7", 7, 0, 6, 1);
    measure("walk6d", 6, 1, 5, 1);
    wait_pede("stop", 5);
    tick();
    check("stop_espera", 32'(db_estado), 32'(S_ESPERA));
    parar = 1'b1;
    tick();
    parar = 1'b0;
    check("stop_estado", 32'(db_estado), 32'(S_OCIOSO));
    check("stop_ocup", 32'(ocupado), 32'd0);
    check("stop_larg", 32'(largura), 32'd5);
    check("stop_dir", 32'(direcao), 32'd1);
    tick();
    tick();
    check("stop_hold", 32'(db_estado), 32'(S_OCIOSO));

    // Restart resumes from the held position.
    iniciar = 1'b1;
    wait_pede("resume", 5);
    check("resume_larg", 32'(largura), 32'd5);
    medir("resume", 4, 1);

    // parar and iniciar together in OCIOSO.
    parar = 1'b1;
    tick();
    check("both_idle", 32'(db_estado), 32'(S_OCIOSO));
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("both_acomoda", 32'(db_estado), 32'(S_ACOMODA));
    check("both_ocup", 32'(ocupado), 32'd1);
    tick();
    parar = 1'b0;
    check("both_back", 32'(db_estado), 32'(S_OCIOSO));
    check("both_pede", 32'(pede_medida), 32'd0);
    check("both_larg", 32'(largura), 32'd4);

    // Reset for two cycles just before a request would be issued.
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    tick();
    check("mid_acomoda", 32'(db_estado), 32'(S_ACOMODA));
    reset = 1'b1;
    tick();
    check("mid_rst_pede1", 32'(pede_medida), 32'd0);
    tick();
    check("mid_rst_pede2", 32'(pede_medida), 32'd0);
    reset = 1'b0;
    check("mid_rst_estado", 32'(db_estado), 32'(S_OCIOSO));
    check("mid_rst_larg", 32'(largura), 32'd0);
    check("mid_rst_dir", 32'(direcao), 32'd0);
    check("mid_rst_ocup", 32'(ocupado), 32'd0);
    check("mid_rst_to", 32'(timeout), 32'd0);
    tick();
    check("mid_rst_after_pede", 32'(pede_medida), 32'd0);
    check("mid_rst_after_estado", 32'(db_estado), 32'(S_OCIOSO));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
